// File: rtl/pin_cmd_responder.sv
// pin_cmd_responder: synchronised pin-level command responder with a 16x8 register file; define CMD_PARITY_EN for odd-parity checking.
module pin_cmd_responder #(
  parameter logic [7:0] RF_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [1:0] warm;
  logic rw;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rf [16];
  logic busy, ack, err;
  logic [4:0] cnt;
  logic [7:0] rdata, oe;
  logic rise, good, unused;
  // history flop only counts once it holds a real sample, so a valid held high through reset is not an edge
  assign rise = s2 & ~s3 & (warm == 2'd3);
  assign unused = &{1'b0, ui_in[5:4]};
`ifdef CMD_PARITY_EN
  logic par;
  assign good = ^{rw, par, addr, rw ? wdata : 8'h00};
`else
  assign good = 1'b1;
`endif
  assign uo_out = {busy, ack, err, cnt};
  assign uio_out = rdata;
  assign uio_oe = oe;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {s1, s2, s3} <= 3'b000;
      warm <= 2'd0;
      {rw, addr, wdata} <= '0;
`ifdef CMD_PARITY_EN
      par <= 1'b0;
`endif
      {busy, ack, err} <= 3'b000;
      cnt <= 5'd0;
      rdata <= 8'h00;
      oe <= 8'h00;
      for (int i = 0; i < 16; i++) rf[i] <= RF_INIT;
    end else begin
      s1 <= ui_in[7];
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      case (state)
        IDLE: if (rise && ena) begin
          state <= EXEC;
          busy <= 1'b1;
          err <= 1'b0;
          rw <= ui_in[6];
          addr <= ui_in[3:0];
          wdata <= uio_in;
`ifdef CMD_PARITY_EN
          par <= ui_in[5];
`endif
        end
        EXEC: begin
          state <= ACK;
          ack <= 1'b1;
          err <= ~good;
          if (rw && good) rf[addr] <= wdata;
          if (!rw) rdata <= rf[addr];
          oe <= (!rw && good) ? 8'hFF : 8'h00;
        end
        ACK: if (!s2) begin
          state <= IDLE;
          {busy, ack} <= 2'b00;
          oe <= 8'h00;
          cnt <= cnt + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pin_cmd_responder.sv
// tb_pin_cmd_responder: directed self-checking bench for pin_cmd_responder.
module tb_pin_cmd_responder;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pin_cmd_responder dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    ui_in = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask
  function automatic logic par_of(input logic rw, input logic [3:0] a, input logic [7:0] d, input logic bad);
    return ~^{rw, a, rw ? d : 8'h00} ^ bad;
  endfunction
  task automatic do_cmd(input logic rw, input logic [3:0] a, input logic [7:0] d, input logic bad,
                        input logic drop_ena, output logic [7:0] rd, output logic [7:0] oe_s);
    int n;
    @(negedge clk);
    ui_in = {1'b1, rw, par_of(rw, a, d, bad), 1'b0, a};
    uio_in = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_ena && uo_out[7]) ena = 1'b0;
    end while (!uo_out[6] && n < 20);
    rd = uio_out;
    oe_s = uio_oe;
    if (!uo_out[6]) begin
      checks++; failures++;
      $display("FAIL cmd_ack_timeout ack=%b required 1", uo_out[6]);
    end
    ui_in[7] = 1'b0;
    n = 0;
    while (uo_out[7] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (uo_out[7]) begin
      checks++; failures++;
      $display("FAIL cmd_idle_timeout busy=%b required 0", uo_out[7]);
    end
    ena = 1'b1;
  endtask
  task automatic test_reset;
    logic [7:0] rd, oe_s;
    rst = 1'b1;
    tick(2);
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold uo_out=%h uio_oe=%h uio_out=%h required 00 00 00", uo_out, uio_oe, uio_out);
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00) begin
      failures++;
      $display("FAIL reset_release uo_out=%h uio_oe=%h required 00 00", uo_out, uio_oe);
    end
    do_cmd(1'b0, 4'h3, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h00 || oe_s !== 8'hFF) begin
      failures++;
      $display("FAIL reset_read3 data=%h oe=%h required 00 FF", rd, oe_s);
    end
  endtask
  task automatic test_write_read;
    logic [7:0] rd, oe_s;
    do_reset();
    do_cmd(1'b1, 4'h4, 8'hA5, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (oe_s !== 8'h00) begin
      failures++;
      $display("FAIL write_oe oe=%h required 00", oe_s);
    end
    do_cmd(1'b0, 4'h4, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'hA5 || oe_s !== 8'hFF) begin
      failures++;
      $display("FAIL read4 data=%h oe=%h required A5 FF", rd, oe_s);
    end
    checks++;
    if (uo_out !== 8'h02 || uio_oe !== 8'h00) begin
      failures++;
      $display("FAIL wr_rd_status uo_out=%h uio_oe=%h required 02 00", uo_out, uio_oe);
    end
  endtask
  task automatic test_latency;
    logic [1:0] b;
    logic a1, a2, a3;
    @(negedge clk);
    ui_in = {1'b1, 1'b0, par_of(1'b0, 4'h4, 8'h00, 1'b0), 1'b0, 4'h4};
    @(negedge clk); b[0] = uo_out[7];
    @(negedge clk); b[1] = uo_out[7];
    checks++;
    if (b !== 2'b00) begin
      failures++;
      $display("FAIL latency_early busy_after_n_n1=%b required 00", b);
    end
    @(negedge clk);
    checks++;
    if (uo_out[7:6] !== 2'b10) begin
      failures++;
      $display("FAIL latency_exec busy_ack=%b required 10", uo_out[7:6]);
    end
    @(negedge clk);
    checks++;
    if (uo_out[7:6] !== 2'b11 || uio_oe !== 8'hFF) begin
      failures++;
      $display("FAIL latency_ack busy_ack=%b oe=%h required 11 FF", uo_out[7:6], uio_oe);
    end
    ui_in[7] = 1'b0;
    @(negedge clk); a1 = uo_out[6];
    @(negedge clk); a2 = uo_out[6];
    @(negedge clk); a3 = uo_out[6];
    checks++;
    if ({a1, a2, a3} !== 3'b110 || uo_out !== 8'h03) begin
      failures++;
      $display("FAIL latency_drop ack_seq=%b uo_out=%h required 110 03", {a1, a2, a3}, uo_out);
    end
  endtask
  task automatic test_gating;
    logic seen;
    logic [7:0] rd, oe_s;
    do_reset();
    ena = 1'b0;
    ui_in = {1'b1, 1'b0, par_of(1'b0, 4'h2, 8'h00, 1'b0), 1'b0, 4'h2};
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= uo_out[7]; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL gate_ena0 busy_seen=%b required 0", seen);
    end
    ena = 1'b1;
    repeat (8) begin @(negedge clk); seen |= uo_out[7]; end
    checks++;
    if (seen !== 1'b0 || uo_out[4:0] !== 5'd0) begin
      failures++;
      $display("FAIL gate_held busy_seen=%b count=%0d required 0 0", seen, uo_out[4:0]);
    end
    ui_in[7] = 1'b0;
    tick(3);
    do_cmd(1'b0, 4'h2, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (uo_out[4:0] !== 5'd1 || oe_s !== 8'hFF) begin
      failures++;
      $display("FAIL gate_after count=%0d oe=%h required 1 FF", uo_out[4:0], oe_s);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] rd, oe_s;
    do_cmd(1'b1, 4'h7, 8'h3C, 1'b0, 1'b1, rd, oe_s);
    checks++;
    if (uo_out[4:0] !== 5'd2) begin
      failures++;
      $display("FAIL ena_drop_count count=%0d required 2", uo_out[4:0]);
    end
    do_cmd(1'b0, 4'h7, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h3C || oe_s !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_read7 data=%h oe=%h required 3C FF", rd, oe_s);
    end
  endtask
  task automatic test_wrap_reset;
    logic [7:0] rd, oe_s;
    int n;
    do_reset();
    for (int i = 0; i < 31; i++) do_cmd(1'b0, 4'(i), 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (uo_out[4:0] !== 5'd31) begin
      failures++;
      $display("FAIL count31 count=%0d required 31", uo_out[4:0]);
    end
    do_cmd(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (uo_out[4:0] !== 5'd0) begin
      failures++;
      $display("FAIL count_wrap count=%0d required 0", uo_out[4:0]);
    end
    do_cmd(1'b1, 4'h5, 8'h11, 1'b0, 1'b0, rd, oe_s);
    @(negedge clk);
    ui_in = {1'b1, 1'b1, par_of(1'b1, 4'h9, 8'h55, 1'b0), 1'b0, 4'h9};
    uio_in = 8'h55;
    n = 0;
    do begin @(negedge clk); n++; end while (!uo_out[6] && n < 20);
    checks++;
    if (uo_out[7:6] !== 2'b11) begin
      failures++;
      $display("FAIL rst_in_ack_reach busy_ack=%b required 11", uo_out[7:6]);
    end
    rst = 1'b1;
    ui_in = 8'h00;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00) begin
      failures++;
      $display("FAIL rst_async uo_out=%h uio_oe=%h required 00 00", uo_out, uio_oe);
    end
    tick(2);
    rst = 1'b0;
    tick(4);
    do_cmd(1'b0, 4'h9, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h00 || uo_out[4:0] !== 5'd1) begin
      failures++;
      $display("FAIL rst_abandon data=%h count=%0d required 00 1", rd, uo_out[4:0]);
    end
    do_cmd(1'b0, 4'h5, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL rst_clears_rf data=%h required 00", rd);
    end
  endtask
  task automatic test_valid_through_reset;
    logic seen;
    logic [7:0] rd, oe_s;
    @(negedge clk);
    rst = 1'b1;
    ui_in = {1'b1, 1'b0, par_of(1'b0, 4'h2, 8'h00, 1'b0), 1'b0, 4'h2};
    tick(2);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= uo_out[7]; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL valid_thru_reset busy_seen=%b required 0", seen);
    end
    ui_in[7] = 1'b0;
    tick(3);
    do_cmd(1'b0, 4'h2, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (uo_out[4:0] !== 5'd1) begin
      failures++;
      $display("FAIL valid_thru_reset_after count=%0d required 1", uo_out[4:0]);
    end
  endtask
  task automatic test_parity;
    logic [7:0] rd, oe_s;
    do_reset();
    do_cmd(1'b1, 4'h1, 8'h11, 1'b0, 1'b0, rd, oe_s);
    do_cmd(1'b1, 4'h1, 8'h77, 1'b1, 1'b0, rd, oe_s);
`ifdef CMD_PARITY_EN
    checks++;
    if (uo_out !== 8'h22) begin
      failures++;
      $display("FAIL parity_bad_write uo_out=%h required 22", uo_out);
    end
    do_cmd(1'b0, 4'h1, 8'h00, 1'b1, 1'b0, rd, oe_s);
    checks++;
    if (oe_s !== 8'h00 || uo_out !== 8'h23) begin
      failures++;
      $display("FAIL parity_bad_read oe=%h uo_out=%h required 00 23", oe_s, uo_out);
    end
    do_cmd(1'b0, 4'h1, 8'h00, 1'b0, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h11 || uo_out !== 8'h04) begin
      failures++;
      $display("FAIL parity_good_after data=%h uo_out=%h required 11 04", rd, uo_out);
    end
`else
    checks++;
    if (uo_out !== 8'h02) begin
      failures++;
      $display("FAIL noparity_err uo_out=%h required 02", uo_out);
    end
    do_cmd(1'b0, 4'h1, 8'h00, 1'b1, 1'b0, rd, oe_s);
    checks++;
    if (rd !== 8'h77 || oe_s !== 8'hFF || uo_out !== 8'h03) begin
      failures++;
      $display("FAIL noparity_read data=%h oe=%h uo_out=%h required 77 FF 03", rd, oe_s, uo_out);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_gating();
    test_back_to_back();
    test_wrap_reset();
    test_valid_through_reset();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pin_cmd_responder.md
PIN_CMD_RESPONDER -- requirements
Module: pin_cmd_responder

Interface
REQ-001 The block SHALL expose parameter RF_INIT, default 8'h00, meaning the value loaded into every register-file entry at reset.
REQ-002 The block SHALL expose port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1, meaning asynchronous active-high reset.
REQ-004 The block SHALL expose port ena, input, 1, meaning design selected; when low, no new command is accepted.
REQ-005 The block SHALL expose port ui_in, input, 8, meaning host command:
- [7] valid, asynchronous to clk
- [6] rw, 1 = write
- [5] parity
- [4] reserved
- [3:0] address
REQ-006 The block SHALL expose port uio_in, input, 8, meaning write data.
REQ-007 The block SHALL expose port uo_out, output, 8, meaning status:
- [7] busy
- [6] ack
- [5] err
- [4:0] transaction count
REQ-008 The block SHALL expose port uio_out, output, 8, meaning read data.
REQ-009 The block SHALL expose port uio_oe, output, 8, meaning bidirectional-pin output enable, 1 = drive.

Function
REQ-010 The block SHALL synchronise ui_in[7] through two flops, plus one history flop for rising-edge detection.
REQ-011 The block SHALL hold a 16 x 8 register file addressed by ui_in[3:0].
REQ-012 The state machine SHALL have states IDLE, EXEC and ACK.
REQ-013 IDLE SHALL move to EXEC on a synchronised rising edge of valid while ena=1, capturing ui_in[6:0] and uio_in in the same cycle.
REQ-014 Acceptance SHALL occur on the third rising clk edge after ui_in[7] rises, given setup is met.
REQ-015 A rising edge of valid while ena=0 SHALL be discarded; it SHALL NOT be remembered for later.
REQ-016 EXEC SHALL last exactly one cycle:
- write: store the captured data at the captured address
- read: load the register-file entry into the uio_out register
- then go to ACK
REQ-017 ACK SHALL hold ack=1 until synchronised valid is low, then return to IDLE on the next edge.
REQ-018 uo_out[7] (busy) SHALL be 1 in EXEC and ACK, and 0 in IDLE.
REQ-019 uo_out[6] (ack) SHALL be 1 only in ACK.
REQ-020 uio_oe SHALL be 8'hFF only in ACK of a read, and 8'h00 otherwise.
REQ-021 uio_out SHALL hold the last read data; its value is don't-care when uio_oe=0.
REQ-022 The transaction count SHALL increment on each ACK-to-IDLE transition and wrap from 31 to 0.
REQ-023 If valid falls during EXEC, the block SHALL still enter ACK for one cycle, then go to IDLE.
REQ-024 If valid re-rises in the cycle ACK exits, no new command SHALL be accepted until a fresh low-to-high edge is seen.
REQ-025 ena falling mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-026 A write immediately followed by a read of the same address SHALL return the new data.

Reset
REQ-027 While rst=1, the block SHALL hold:
- state IDLE
- synchroniser flops 0
- uo_out 8'h00
- uio_out 8'h00
- uio_oe 8'h00
- every register-file entry RF_INIT
REQ-028 Reset asserted mid-transaction SHALL abandon it without a register-file write and without a count increment.
REQ-029 After reset release, a valid already high SHALL NOT count as an edge until it has been seen low.

Configuration
REQ-030 With CMD_PARITY_EN defined, the block SHALL check in EXEC that the XOR of ui_in[6], ui_in[5], ui_in[3:0], and uio_in on writes, is 1 (odd parity).
REQ-031 With CMD_PARITY_EN defined and parity bad, the block SHALL set err, suppress the write, and drive uio_oe=8'h00 on a read; the block SHALL still pass through ACK and count the transaction.
REQ-032 err SHALL stay set until the next accepted command.
REQ-033 Without CMD_PARITY_EN, the block SHALL ignore ui_in[5] and tie err to 0.

Verification
REQ-034 Reset: after rst pulse -> uo_out=8'h00, uio_oe=8'h00; a read of address 3 returns 8'h00.
REQ-035 Write/read: write 8'hA5 to address 4, then read address 4 -> uio_out=8'hA5 with uio_oe=8'hFF during ACK; count=2.
REQ-036 Latency: valid rises before edge N -> busy=1 after edge N+2; valid drops -> ack=0 within 3 edges.
REQ-037 Gating: ena=0 during a valid edge -> no busy and count unchanged; then ena=1 with valid held high -> still no acceptance.
REQ-038 Wrap and reset: 32 transactions -> count=0; rst asserted in ACK of a write -> count=0 and entry reads RF_INIT.
REQ-039 CMD_PARITY_EN: write with bad parity to address 1 -> err=1, entry unchanged; next good command -> err=0.
